// File: rtl/cmd_crc16_rx_if.sv
// Bus between the PIE bit decoder / command parser and the CRC-16 receive
// framing stage. The master side drives the serial frame; the slave side
// (cmd_crc16_rx) returns status and the one-shot verdict.
// Optional macro CMD_CRC_ERRCNT_EN adds err_clr / err_count.
interface cmd_crc16_rx_if;
    logic        frame_start;
    logic        frame_end;
    logic        bit_valid;
    logic        bit_in;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        len_err;
    logic [9:0]  bit_count;
    logic [15:0] crc_out;
`ifdef CMD_CRC_ERRCNT_EN
    logic        err_clr;
    logic [7:0]  err_count;

    modport master (
        output frame_start, frame_end, bit_valid, bit_in, err_clr,
        input  busy, done, crc_ok, len_err, bit_count, crc_out, err_count
    );

    modport slave (
        input  frame_start, frame_end, bit_valid, bit_in, err_clr,
        output busy, done, crc_ok, len_err, bit_count, crc_out, err_count
    );
`else
    modport master (
        output frame_start, frame_end, bit_valid, bit_in,
        input  busy, done, crc_ok, len_err, bit_count, crc_out
    );

    modport slave (
        input  frame_start, frame_end, bit_valid, bit_in,
        output busy, done, crc_ok, len_err, bit_count, crc_out
    );
`endif
endinterface

// File: rtl/cmd_crc16_rx.sv
// cmd_crc16_rx: receive-side CRC-16 (x^16+x^12+x^5+1, preset FFFF) framing
// stage for Select/ReqRN/Read/Write/SensData. Accumulates the CRC serially,
// counts bits, checks frame length and issues a one-shot verdict two cycles
// after frame_end. A frame_start in any state restarts the frame.
// Optional macro CMD_CRC_ERRCNT_EN adds a saturating bad-verdict counter
// (err_count) with a synchronous clear (err_clr).
module cmd_crc16_rx #(
    parameter int          MIN_BITS = 40,
    parameter int          MAX_BITS = 1000,
    parameter logic [15:0] RESIDUE  = 16'h1D0F
) (
    input  logic          clk,
    input  logic          reset,
    cmd_crc16_rx_if.slave bus
);

    localparam logic [9:0]  MIN_C    = 10'(MIN_BITS);
    localparam logic [9:0]  LIMIT_C  = 10'(MAX_BITS + 1);
    localparam logic [15:0] PRESET_C = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RX    = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_crc;
    logic [9:0]  r_bit_count;
    logic        r_busy;
    logic        r_done;
    logic        r_crc_ok;
    logic        r_len_err;

    logic        w_overflow;
    logic        w_accept;
    logic        w_len_err_next;
    logic        w_crc_ok_next;
    logic        w_verdict;

    // One serial CRC-16 step, MSB-first: feedback taps into bits 0, 5 and 12.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic        fb;
        logic [15:0] nxt;
        fb      = b ^ crc[15];
        nxt     = {crc[14:0], fb};
        nxt[5]  = crc[4] ^ fb;
        nxt[12] = crc[11] ^ fb;
        return nxt;
    endfunction

    // Count saturates at MAX_BITS+1; reaching it marks the frame as too long.
    assign w_overflow     = (r_bit_count == LIMIT_C);
    // A bit alongside frame_start is bit 0 of the new frame, whatever the state.
    assign w_accept       = bus.bit_valid & (bus.frame_start | ((r_state == ST_RX) & ~w_overflow));
    assign w_len_err_next = (r_bit_count < MIN_C) | w_overflow;
    assign w_crc_ok_next  = (r_crc == RESIDUE) & ~w_len_err_next;
    // A restart during CHECK abandons the frame, so no verdict is issued.
    assign w_verdict      = (r_state == ST_CHECK) & ~bus.frame_start;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: frame_start always wins and (re)enters RX.
    always_comb begin
        w_state_next = r_state;
        if (bus.frame_start) begin
            w_state_next = ST_RX;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_IDLE;
                ST_RX: begin
                    if (bus.frame_end) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_state_next = ST_RX;
                    end
                end
                ST_CHECK: w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: CRC accumulation, bit counting and the registered verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc       <= PRESET_C;
            r_bit_count <= 10'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= 1'b0;
            if (bus.frame_start) begin
                r_crc       <= w_accept ? crc16_step(PRESET_C, bus.bit_in) : PRESET_C;
                r_bit_count <= w_accept ? 10'd1 : 10'd0;
                r_crc_ok    <= 1'b0;
                r_len_err   <= 1'b0;
            end else if (w_verdict) begin
                r_done    <= 1'b1;
                r_len_err <= w_len_err_next;
                r_crc_ok  <= w_crc_ok_next;
            end else if (w_accept) begin
                r_crc       <= crc16_step(r_crc, bus.bit_in);
                r_bit_count <= r_bit_count + 10'd1;
            end else begin
                r_crc       <= r_crc;
                r_bit_count <= r_bit_count;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.crc_ok    = r_crc_ok;
    assign bus.len_err   = r_len_err;
    assign bus.bit_count = r_bit_count;
    assign bus.crc_out   = r_crc;

`ifdef CMD_CRC_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating count of failed verdicts; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (bus.err_clr) begin
            r_err_count <= 8'd0;
        end else if (w_verdict && !w_crc_ok_next && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_cmd_crc16_rx.sv
// Self-checking bench for cmd_crc16_rx: directed frames, with the expected
// verdict pushed into a scoreboard queue when frame_end is driven and popped
// by an independent monitor whenever done is seen.
module tb_cmd_crc16_rx;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    cmd_crc16_rx_if bus();

    cmd_crc16_rx #(
        .MIN_BITS (40),
        .MAX_BITS (1000),
        .RESIDUE  (16'h1D0F)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ok;
        logic        le;
        logic [9:0]  cnt;
        logic [15:0] crc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [39:0] good_frame;
    logic [39:0] bad_frame;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference CRC: textbook shift-and-xor with polynomial 0x1021.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
        logic [15:0] sh;
        sh = {c[14:0], 1'b0};
        return ((b ^ c[15]) == 1'b1) ? (sh ^ 16'h1021) : sh;
    endfunction

    function automatic logic pat(input int i);
        return i[1] ^ i[4] ^ i[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        bus.frame_start = 1'b1;
        sync();
        bus.frame_start = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        sync();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send40(input logic [39:0] f, input int first, input int last);
        for (int j = first; j <= last; j++) drive_bit(f[39 - j]);
    endtask

    task automatic finish(input logic with_bit, input logic b, input exp_t e);
        exp_t e2;
        e2            = e;
        e2.cyc        = cyc + 2;
        exp_q.push_back(e2);
        bus.frame_end = 1'b1;
        bus.bit_valid = with_bit;
        bus.bit_in    = b;
        sync();
        bus.frame_end = 1'b0;
        bus.bit_valid = 1'b0;
        repeat (4) sync();
    endtask

    function automatic exp_t mk(input logic ok, input logic le, input logic [9:0] cnt, input logic [15:0] crc);
        exp_t e;
        e.ok = ok; e.le = le; e.cnt = cnt; e.crc = crc; e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("crc_ok", {31'd0, bus.crc_ok}, {31'd0, e.ok});
                check("len_err", {31'd0, bus.len_err}, {31'd0, e.le});
                check("bit_count", {22'd0, bus.bit_count}, {22'd0, e.cnt});
                check("crc_out", {16'd0, bus.crc_out}, {16'd0, e.crc});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] c;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
`ifdef CMD_CRC_ERRCNT_EN
        bus.err_clr     = 1'b0;
`endif
        // ReqRN: 0xC1 + handle 0x1234 + complemented CRC.
        c = 16'hFFFF;
        for (int j = 23; j >= 0; j--) c = ref_crc(c, 24'hC11234 >> j);
        good_frame = {24'hC11234, ~c};
        bad_frame  = good_frame;
        bad_frame[39 - 7] = ~bad_frame[39 - 7];

        repeat (3) sync();
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
        check("rst_len_err", {31'd0, bus.len_err}, 32'd0);
        check("rst_bit_count", {22'd0, bus.bit_count}, 32'd0);
        check("rst_crc_out", {16'd0, bus.crc_out}, 32'h0000FFFF);
        sync();

        // 1: good ReqRN.
        start();
        send40(good_frame, 0, 4);
        @(negedge clk);
        check("rx_busy", {31'd0, bus.busy}, 32'd1);
        sync();
        send40(good_frame, 5, 39);
        finish(1'b0, 1'b0, mk(1'b1, 1'b0, 10'd40, 16'h1D0F));

        // IDLE ignores bits and frame_end; results hold.
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus.frame_end = 1'b1;
        sync();
        bus.frame_end = 1'b0;
        repeat (3) sync();
        @(negedge clk);
        check("hold_bit_count", {22'd0, bus.bit_count}, 32'd40);
        check("hold_crc_out", {16'd0, bus.crc_out}, 32'h00001D0F);
        check("hold_crc_ok", {31'd0, bus.crc_ok}, 32'd1);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        sync();

        // 2: bit 7 flipped.
        c = 16'hFFFF;
        for (int j = 0; j < 40; j++) c = ref_crc(c, bad_frame[39 - j]);
        start();
        send40(bad_frame, 0, 39);
        finish(1'b0, 1'b0, mk(1'b0, 1'b0, 10'd40, c));

        // Last bit together with frame_end is included.
        start();
        send40(good_frame, 0, 38);
        finish(1'b1, good_frame[0], mk(1'b1, 1'b0, 10'd40, 16'h1D0F));

        // 3: empty frame.
        start();
        finish(1'b0, 1'b0, mk(1'b0, 1'b1, 10'd0, 16'hFFFF));

        // 4: 1005 bits, count saturates at 1001.
        c = 16'hFFFF;
        for (int i = 0; i < 1001; i++) c = ref_crc(c, pat(i));
        start();
        for (int i = 0; i < 1005; i++) drive_bit(pat(i));
        finish(1'b0, 1'b0, mk(1'b0, 1'b1, 10'd1001, c));

        // 5: restart mid-frame with frame_start + bit_valid.
        start();
        for (int i = 0; i < 12; i++) drive_bit(pat(i + 3));
        bus.frame_start = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.bit_in      = good_frame[39];
        sync();
        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        send40(good_frame, 1, 39);
        finish(1'b0, 1'b0, mk(1'b1, 1'b0, 10'd40, 16'h1D0F));

        // 6: reset at bit 20.
        start();
        send40(good_frame, 0, 19);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_crc_out", {16'd0, bus.crc_out}, 32'h0000FFFF);
        check("midrst_bit_count", {22'd0, bus.bit_count}, 32'd0);
        sync();
        repeat (5) sync();

`ifdef CMD_CRC_ERRCNT_EN
        @(negedge clk);
        check("errcnt_after_rst", {24'd0, bus.err_count}, 32'd0);
        sync();
        c = 16'hFFFF;
        for (int j = 0; j < 40; j++) c = ref_crc(c, bad_frame[39 - j]);
        for (int k = 0; k < 3; k++) begin
            start();
            send40(bad_frame, 0, 39);
            finish(1'b0, 1'b0, mk(1'b0, 1'b0, 10'd40, c));
        end
        @(negedge clk);
        check("errcnt_three", {24'd0, bus.err_count}, 32'd3);
        sync();
        bus.err_clr = 1'b1;
        sync();
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("errcnt_clr", {24'd0, bus.err_count}, 32'd0);
        sync();
`endif

        repeat (4) sync();
        check("pending_verdicts", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
